// File: rtl/score_keeper_pkg.sv
// ============================================================================
// score_pkg : shared FSM state, winner encodings and score limit for
//             score_keeper.   Rev 1.0
// ============================================================================
`default_nettype none

package score_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PLAY    = 2'd1,
      S_HOLDOFF = 2'd2,
      S_OVER    = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam int MAX_SCORE = 999;

endpackage

`default_nettype wire

// File: rtl/score_keeper_bcd.sv
// ============================================================================
// bcd_counter3 : three-digit BCD incrementer with synchronous clear.
//                Rev 1.0
// ============================================================================
`default_nettype none

module bcd_counter3 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        inc,
   output logic [11:0] bcd
);

   logic [3:0] units_q, units_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] hund_q, hund_d;

   always_comb begin
      units_d = units_q;
      tens_d  = tens_q;
      hund_d  = hund_q;
      if (clr) begin
         units_d = 4'd0;
         tens_d  = 4'd0;
         hund_d  = 4'd0;
      end else if (inc) begin
         if (units_q == 4'd9) begin
            units_d = 4'd0;
            if (tens_q == 4'd9) begin
               tens_d = 4'd0;
               hund_d = (hund_q == 4'd9) ? 4'd0 : hund_q + 4'd1;
            end else begin
               tens_d = tens_q + 4'd1;
            end
         end else begin
            units_d = units_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         units_q <= 4'd0;
         tens_q  <= 4'd0;
         hund_q  <= 4'd0;
      end else begin
         units_q <= units_d;
         tens_q  <= tens_d;
         hund_q  <= hund_d;
      end
   end

   assign bcd = {hund_q, tens_q, units_q};

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : two-player match scorer with hit edge detection, post-point
//                holdoff and win detection.  Optional BCD outputs enabled by
//                defining SCORE_KEEPER_BCD_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module score_keeper
   import score_pkg::*;
#(
   parameter int WIN_SCORE = 10,
   parameter int HOLDOFF   = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        hit_p1,
   input  logic        hit_p2,
   output logic [9:0]  score1,
   output logic [9:0]  score2,
   output logic [11:0] bcd1,
   output logic [11:0] bcd2,
   output logic        point,
   output logic        game_over,
   output logic [1:0]  winner
);

   localparam int             WIN_I     = (WIN_SCORE > MAX_SCORE) ? MAX_SCORE : WIN_SCORE;
   localparam logic [9:0]     WIN_L     = WIN_I[9:0];
   localparam int             CW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [CW-1:0]  HOLD_INIT = CW'(HOLDOFF - 1);

   state_t        state_q, state_d;
   logic [9:0]    score1_q, score1_d;
   logic [9:0]    score2_q, score2_d;
   logic [1:0]    winner_q, winner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          point_q, point_d;
   logic          hit_p1_q, hit_p2_q;
   logic          edge_p1, edge_p2;
   logic          start_clr;

   // Hit history is tracked in every state so a held level never re-scores.
   assign edge_p1   = hit_p1 & ~hit_p1_q;
   assign edge_p2   = hit_p2 & ~hit_p2_q;
   assign start_clr = start & ((state_q == S_IDLE) | (state_q == S_OVER));

   always_comb begin
      state_d  = state_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      cnt_d    = cnt_q;
      point_d  = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               score1_d = 10'd0;
               score2_d = 10'd0;
               winner_d = WIN_NONE;
               state_d  = S_PLAY;
            end
         end
         S_PLAY: begin
            if (edge_p1 & edge_p2) begin
               point_d = 1'b1;
               cnt_d   = HOLD_INIT;
               state_d = S_HOLDOFF;
            end else if (edge_p2) begin
               score1_d = score1_q + 10'd1;
               point_d  = 1'b1;
               cnt_d    = HOLD_INIT;
               state_d  = S_HOLDOFF;
               if (score1_d == WIN_L) begin
                  winner_d = WIN_P1;
                  state_d  = S_OVER;
               end
            end else if (edge_p1) begin
               score2_d = score2_q + 10'd1;
               point_d  = 1'b1;
               cnt_d    = HOLD_INIT;
               state_d  = S_HOLDOFF;
               if (score2_d == WIN_L) begin
                  winner_d = WIN_P2;
                  state_d  = S_OVER;
               end
            end
         end
         S_HOLDOFF: begin
            if (cnt_q == '0) state_d = S_PLAY;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         score1_q <= 10'd0;
         score2_q <= 10'd0;
         winner_q <= WIN_NONE;
         cnt_q    <= '0;
         point_q  <= 1'b0;
         hit_p1_q <= 1'b0;
         hit_p2_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         winner_q <= winner_d;
         cnt_q    <= cnt_d;
         point_q  <= point_d;
         hit_p1_q <= hit_p1;
         hit_p2_q <= hit_p2;
      end
   end

   assign score1    = score1_q;
   assign score2    = score2_q;
   assign winner    = winner_q;
   assign point     = point_q;
   assign game_over = (state_q == S_OVER);

`ifdef SCORE_KEEPER_BCD_EN
   logic bcd_inc1, bcd_inc2;

   assign bcd_inc1 = (state_q == S_PLAY) & (score1_d != score1_q);
   assign bcd_inc2 = (state_q == S_PLAY) & (score2_d != score2_q);

   bcd_counter3 u_bcd1 (
      .clk   (clk),
      .reset (reset),
      .clr   (start_clr),
      .inc   (bcd_inc1),
      .bcd   (bcd1)
   );

   bcd_counter3 u_bcd2 (
      .clk   (clk),
      .reset (reset),
      .clr   (start_clr),
      .inc   (bcd_inc2),
      .bcd   (bcd2)
   );
`else
   logic unused_clr;
   assign unused_clr = start_clr;
   assign bcd1 = 12'h000;
   assign bcd2 = 12'h000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// tb_score_keeper : directed self-checking bench for score_keeper.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: WIN_SCORE=3, HOLDOFF=4
   logic        reset_a, start_a, hp1_a, hp2_a;
   logic [9:0]  s1_a, s2_a;
   logic [11:0] b1_a, b2_a;
   logic        pt_a, go_a;
   logic [1:0]  win_a;

   // DUT B: WIN_SCORE=999, HOLDOFF=4
   logic        reset_b, start_b, hp1_b, hp2_b;
   logic [9:0]  s1_b, s2_b;
   logic [11:0] b1_b, b2_b;
   logic        pt_b, go_b;
   logic [1:0]  win_b;

   score_keeper #(.WIN_SCORE(3), .HOLDOFF(4)) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .hit_p1(hp1_a), .hit_p2(hp2_a),
      .score1(s1_a), .score2(s2_a), .bcd1(b1_a), .bcd2(b2_a),
      .point(pt_a), .game_over(go_a), .winner(win_a)
   );

   score_keeper #(.WIN_SCORE(999), .HOLDOFF(4)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .hit_p1(hp1_b), .hit_p2(hp2_b),
      .score1(s1_b), .score2(s2_b), .bcd1(b1_b), .bcd2(b2_b),
      .point(pt_b), .game_over(go_b), .winner(win_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [11:0] exp_b10, exp_b12;
   int pulses;

   initial begin
`ifdef SCORE_KEEPER_BCD_EN
      exp_b10 = 12'h010;
      exp_b12 = 12'h012;
`else
      exp_b10 = 12'h000;
      exp_b12 = 12'h000;
`endif
      reset_a = 1; start_a = 0; hp1_a = 0; hp2_a = 0;
      reset_b = 1; start_b = 0; hp1_b = 0; hp2_b = 0;
      step(2);
      chk("rst_score1", 32'(s1_a), 0);
      chk("rst_score2", 32'(s2_a), 0);
      chk("rst_bcd1", 32'(b1_a), 0);
      chk("rst_point", 32'(pt_a), 0);
      chk("rst_game_over", 32'(go_a), 0);
      chk("rst_winner", 32'(win_a), 0);

      // Hits in IDLE are ignored
      reset_a = 0; reset_b = 0;
      hp2_a = 1; step(1); hp2_a = 0; step(1);
      chk("idle_hit_ignored", 32'(s1_a), 0);

      // Start -> PLAY
      start_a = 1; start_b = 1; step(1); start_a = 0; start_b = 0;
      chk("start_score1", 32'(s1_a), 0);
      chk("start_winner", 32'(win_a), 0);
      chk("start_game_over", 32'(go_a), 0);

      // hit_p2 held for 10 cycles scores once
      hp2_a = 1; step(1);
      chk("hold_score1", 32'(s1_a), 1);
      chk("hold_point", 32'(pt_a), 1);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         step(1);
         pulses += int'(pt_a);
      end
      hp2_a = 0; step(3);
      chk("hold_no_extra_point", 32'(pulses), 0);
      chk("hold_score1_after", 32'(s1_a), 1);
      chk("hold_score2_after", 32'(s2_a), 0);

      // hit_p1 edge; second edge inside holdoff ignored; edge at +6 scores
      hp1_a = 1; step(1);
      chk("p1_first_score2", 32'(s2_a), 1);
      chk("p1_first_point", 32'(pt_a), 1);
      hp1_a = 0; step(1);
      hp1_a = 1; step(1);
      chk("p1_holdoff_score2", 32'(s2_a), 1);
      chk("p1_holdoff_point", 32'(pt_a), 0);
      hp1_a = 0; step(3);
      hp1_a = 1; step(1);
      chk("p1_third_score2", 32'(s2_a), 2);
      chk("p1_third_point", 32'(pt_a), 1);
      hp1_a = 0; step(6);

      // Simultaneous edges: draw
      hp1_a = 1; hp2_a = 1; step(1);
      chk("draw_score1", 32'(s1_a), 1);
      chk("draw_score2", 32'(s2_a), 2);
      chk("draw_point", 32'(pt_a), 1);
      hp1_a = 0; hp2_a = 0; step(1);
      chk("draw_point_drop", 32'(pt_a), 0);
      hp2_a = 1; step(1); hp2_a = 0;
      chk("draw_holdoff_ignores", 32'(s1_a), 1);
      step(6);

      // Reach WIN_SCORE=3 for player 1
      hp2_a = 1; step(1); hp2_a = 0;
      chk("win_score1_2", 32'(s1_a), 2);
      chk("win_not_over", 32'(go_a), 0);
      step(6);
      hp2_a = 1; step(1); hp2_a = 0;
      chk("win_score1_3", 32'(s1_a), 3);
      chk("win_game_over", 32'(go_a), 1);
      chk("win_winner", 32'(win_a), 1);
      chk("win_point", 32'(pt_a), 1);
      step(1);
      hp1_a = 1; step(1); hp1_a = 0; step(1);
      hp2_a = 1; step(1); hp2_a = 0; step(1);
      chk("over_score1_held", 32'(s1_a), 3);
      chk("over_score2_held", 32'(s2_a), 2);
      chk("over_still_over", 32'(go_a), 1);
      chk("over_winner_held", 32'(win_a), 1);

      // Restart
      start_a = 1; step(1); start_a = 0;
      chk("restart_score1", 32'(s1_a), 0);
      chk("restart_score2", 32'(s2_a), 0);
      chk("restart_winner", 32'(win_a), 0);
      chk("restart_game_over", 32'(go_a), 0);
      hp1_a = 1; step(1); hp1_a = 0;
      chk("restart_plays", 32'(s2_a), 1);

      // Reset during HOLDOFF on DUT A
      reset_a = 1; step(1); reset_a = 0;
      chk("rstmid_a_score2", 32'(s2_a), 0);
      chk("rstmid_a_point", 32'(pt_a), 0);
      hp2_a = 1; step(1); hp2_a = 0;
      chk("rstmid_a_idle", 32'(s1_a), 0);

      // DUT B: 12 spaced points for player 1
      for (int i = 0; i < 12; i++) begin
         hp2_b = 1; step(1); hp2_b = 0;
         if (i == 9) chk("b_bcd1_10", 32'(b1_b), 32'(exp_b10));
         if (i < 11) step(5);
      end
      chk("b_score1_12", 32'(s1_b), 12);
      chk("b_bcd1_12", 32'(b1_b), 32'(exp_b12));
      chk("b_bcd2_0", 32'(b2_b), 0);
      chk("b_point", 32'(pt_b), 1);

      // Reset while in HOLDOFF
      step(1);
      reset_b = 1; step(1); reset_b = 0;
      chk("b_rst_score1", 32'(s1_b), 0);
      chk("b_rst_bcd1", 32'(b1_b), 0);
      chk("b_rst_point", 32'(pt_b), 0);
      chk("b_rst_game_over", 32'(go_b), 0);
      chk("b_rst_winner", 32'(win_b), 0);
      hp2_b = 1; step(1); hp2_b = 0;
      chk("b_rst_idle", 32'(s1_b), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 10: points needed to win; legal range 1..999.
REQ-002 Parameter HOLDOFF, default 25000000: cycles during which hits are ignored after a point; legal range ≥1.
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  level; starts or restarts a match.
REQ-006 hit_p1  in  1  level from player-1 collision logic; awards a point to player 2.
REQ-007 hit_p2  in  1  level from player-2 collision logic; awards a point to player 1.
REQ-008 score1  out  10  binary score of player 1, range 0..999; feeds HEX3..HEX5 display path.
REQ-009 score2  out  10  binary score of player 2, range 0..999; feeds HEX0..HEX2 display path.
REQ-010 bcd1, bcd2  out  12  three BCD digits of score1/score2 as [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-011 point  out  1  one-cycle pulse on every scoring event, including a draw.
REQ-012 game_over  out  1  high while in state OVER.
REQ-013 winner  out  2  00 none, 01 player 1, 10 player 2; 11 is never driven.

Function
REQ-014 The FSM SHALL have states IDLE, PLAY, HOLDOFF and OVER.
REQ-015 Hits: hit_px SHALL register its previous value; edge_px = hit_px & ~hit_px_q; a level held high counts once.
REQ-016 IDLE or OVER with start=1: clear scores, BCD and winner; go to PLAY next cycle.
REQ-017 PLAY or HOLDOFF with start=1: no effect.
REQ-018 PLAY with exactly one edge: increment the opposing score by 1, pulse point, enter HOLDOFF with counter=HOLDOFF-1.
REQ-019 PLAY with both edges in the same cycle: draw; no score change, pulse point, enter HOLDOFF.
REQ-020 Latency: an edge in cycle N SHALL make the updated score, BCD and point visible in cycle N+1.
REQ-021 HOLDOFF SHALL ignore all edges, decrement its counter each cycle, and return to PLAY in the cycle after the counter reads 0.
REQ-022 Edges still update hit_px_q during HOLDOFF, IDLE and OVER, so a level held across HOLDOFF does not score afterwards.
REQ-023 Win: an increment that makes a score equal WIN_SCORE SHALL enter OVER instead of HOLDOFF, set winner, and assert game_over in the same cycle N+1.
REQ-024 OVER SHALL hold scores and winner and ignore hits until start.
REQ-025 Arithmetic: scores are 10-bit unsigned and never exceed WIN_SCORE, so no wrap occurs.
REQ-026 BCD: bcd units carry to tens at 9, and tens carry to hundreds at 9.
REQ-027 IDLE SHALL ignore hits.

Reset
REQ-028 Reset SHALL set state=IDLE, score1=score2=0, bcd1=bcd2=0, point=0, game_over=0, winner=00, the holdoff counter to 0, and hit_px_q=0.
REQ-029 Reset SHALL take priority over start and hits, and SHALL abort PLAY, HOLDOFF or OVER mid-operation.

Configuration
REQ-030 With SCORE_KEEPER_BCD_EN defined, bcd1/bcd2 SHALL be driven by internal BCD counters in lockstep with the binary scores.
REQ-031 Without SCORE_KEEPER_BCD_EN, the bcd1/bcd2 ports SHALL remain present, be tied to 12'h000, and no BCD counters are instantiated.

Structure
REQ-032 Package score_pkg SHALL hold the FSM state enum, the winner encodings (WIN_NONE, WIN_P1, WIN_P2) and MAX_SCORE=999.
REQ-033 Sub-module bcd_counter3 SHALL be a three-digit BCD incrementer with synchronous clear and an inc input, instantiated twice under the macro.

Verification (WIN_SCORE=3, HOLDOFF=4)
REQ-034 Reset, then start pulse -> PLAY next cycle; all outputs 0, winner=00.
REQ-035 hit_p2 high for 10 cycles -> score1=1 one cycle after the edge, point pulses once, no second point after HOLDOFF ends.
REQ-036 hit_p1 edge, then another edge 2 cycles later -> score2=1 only; an edge 6 cycles after the first -> score2=2.
REQ-037 Simultaneous hit_p1/hit_p2 edges -> scores unchanged, point=1 for one cycle, HOLDOFF entered.
REQ-038 Three spaced hit_p2 edges -> score1=3, game_over=1, winner=01; further hits are ignored; start clears scores and re-enters PLAY.
REQ-039 Build with WIN_SCORE=999 and SCORE_KEEPER_BCD_EN, then drive 12 spaced points -> bcd1=12'h012; assert reset during HOLDOFF -> all outputs 0 and state IDLE next cycle.
